// File: rtl/line_window_3x3.sv
// Streaming 3x3 window generator: two line buffers plus a 3x3 tap array,
// emitting one window per accepted interior pixel with frame tracking.
module line_window_3x3 #(
  parameter int unsigned IMG_W = 630,
  parameter int unsigned IMG_H = 630,
  parameter int unsigned CW    = 10
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          frame_start,
  input  logic [7:0]    pix_in,
  input  logic          pix_valid,
  output logic [7:0]    p00,
  output logic [7:0]    p01,
  output logic [7:0]    p02,
  output logic [7:0]    p10,
  output logic [7:0]    p11,
  output logic [7:0]    p12,
  output logic [7:0]    p20,
  output logic [7:0]    p21,
  output logic [7:0]    p22,
  output logic          win_valid,
  output logic [CW-1:0] win_x,
  output logic [CW-1:0] win_y,
  output logic          frame_done
);

  localparam int unsigned AW = (IMG_W > 1) ? $clog2(IMG_W) : 1;

  typedef enum logic [1:0] {IDLE, ACTIVE, DONE} state_t;

  state_t        state;
  logic [CW-1:0] c;
  logic [CW-1:0] r;

  logic [7:0] lb1 [IMG_W];
  logic [7:0] lb2 [IMG_W];

  logic          load_c;
  logic          adv_c;
  logic          acc_c;
  logic [AW-1:0] addr_c;
  logic [7:0]    rd1_c;
  logic [7:0]    rd2_c;
  logic          last_col_c;
  logic          last_row_c;
  logic          emit_c;

  // A frame_start accept always restarts at column 0, whatever the state.
  always_comb begin
    load_c     = pix_valid & frame_start;
    adv_c      = pix_valid & ~frame_start & (state == ACTIVE);
    acc_c      = load_c | adv_c;
    addr_c     = load_c ? '0 : AW'(c);
    rd1_c      = lb1[addr_c];
    rd2_c      = lb2[addr_c];
    last_col_c = (c == CW'(IMG_W - 1));
    last_row_c = (r == CW'(IMG_H - 1));
    emit_c     = adv_c & (c >= CW'(2)) & (r >= CW'(2));
  end

  // Line buffers are plain storage with no reset so they map onto RAM.
  always_ff @(posedge clk) begin
    if (acc_c) begin
      lb2[addr_c] <= rd1_c;
      lb1[addr_c] <= pix_in;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      c          <= '0;
      r          <= '0;
      win_valid  <= 1'b0;
      frame_done <= 1'b0;
      win_x      <= '0;
      win_y      <= '0;
      p00 <= '0; p01 <= '0; p02 <= '0;
      p10 <= '0; p11 <= '0; p12 <= '0;
      p20 <= '0; p21 <= '0; p22 <= '0;
    end else begin
      win_valid  <= emit_c;
      frame_done <= (state == DONE);

      if (acc_c) begin
        p00 <= p01; p01 <= p02; p02 <= rd2_c;
        p10 <= p11; p11 <= p12; p12 <= rd1_c;
        p20 <= p21; p21 <= p22; p22 <= pix_in;
      end

      if (emit_c) begin
        win_x <= c - CW'(1);
        win_y <= r - CW'(1);
      end

      if (load_c) begin
        c     <= CW'(1);
        r     <= '0;
        state <= ACTIVE;
      end else begin
        case (state)
          ACTIVE: begin
            if (adv_c) begin
              if (last_col_c) begin
                c <= '0;
                if (last_row_c) begin
                  state <= DONE;
                end else begin
                  r <= r + CW'(1);
                end
              end else begin
                c <= c + CW'(1);
              end
            end
          end
          DONE:    state <= IDLE;
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule
